// File: rtl/mm_div_seq_pkg.sv
// Shared definitions for the sequential divider.
//   bit_width : default operand widths (divisor/quotient/remainder and dividend).
//   mm_defs   : divider FSM state encoding and the nominal clock period.
package bit_width;
  parameter int INWIDTH  = 16;
  parameter int OUTWIDTH = 2 * INWIDTH;
endpackage

package mm_defs;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int CLOCK_PERIOD = 10;
endpackage

// File: rtl/mm_div_seq_step.sv
// mm_div_step: one combinational restoring-division iteration.
// Ports:
//   r_i    : partial remainder (always < d_i, so its extra MSB is zero and not carried)
//   bit_i  : next dividend bit shifted into the remainder
//   d_i    : divisor
//   r_o    : next partial remainder
//   qbit_o : quotient bit produced by this step
module mm_div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] r_i,
  input  logic         bit_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] r_o,
  output logic         qbit_o
);
  logic [W:0] trial;

  assign trial  = {r_i, bit_i};
  assign qbit_o = (trial >= {1'b0, d_i});
  // When the subtraction happens the result is < d_i, so it fits in W bits.
  assign r_o    = qbit_o ? W'(trial - {1'b0, d_i}) : trial[W-1:0];
endmodule

// File: rtl/mm_div_seq.sv
// mm_div_seq: sequential unsigned restoring divider, one quotient bit per clock.
// Handshake: a side transfers on a rising edge where its valid and ready are
// both high; the producer holds valid and data stable until then.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in idle)
//   dividend, divisor   : OUTWIDTH-bit dividend, INWIDTH-bit divisor, sampled on accept
//   out_valid/out_ready : result handshake, result held until accepted
//   quotient, remainder : INWIDTH-bit results
//   dbz, ovf            : divide-by-zero / quotient-overflow flags (qualified by out_valid)
//   dbg_state           : current FSM state, for observation only
module mm_div_seq
  import mm_defs::*;
#(
  parameter int INWIDTH  = bit_width::INWIDTH,
  parameter int OUTWIDTH = 2 * INWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OUTWIDTH-1:0] dividend,
  input  logic [INWIDTH-1:0]  divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INWIDTH-1:0]  quotient,
  output logic [INWIDTH-1:0]  remainder,
  output logic                dbz,
  output logic                ovf,
  output logic [1:0]          dbg_state
);
  localparam int CW = $clog2(INWIDTH + 1);

  div_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [INWIDTH-1:0] r_q, r_d;     // partial remainder; its (INWIDTH+1)th bit is always 0
  logic [INWIDTH-1:0] q_q, q_d;     // dividend low half shifting out, quotient shifting in
  logic [INWIDTH-1:0] d_q, d_d;
  logic [INWIDTH-1:0] quot_q, quot_d;
  logic [INWIDTH-1:0] rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic [INWIDTH-1:0] step_r;
  logic               step_qbit;

  mm_div_step #(.W(INWIDTH)) u_step (
    .r_i   (r_q),
    .bit_i (q_q[INWIDTH-1]),
    .d_i   (d_q),
    .r_o   (step_r),
    .qbit_o(step_qbit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend[INWIDTH-1:0];
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = DIV_DONE;
          end else if (dividend[OUTWIDTH-1:INWIDTH] >= divisor) begin
            // Quotient would not fit in INWIDTH bits.
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = DIV_DONE;
          end else begin
            r_d     = dividend[OUTWIDTH-1:INWIDTH];
            q_d     = dividend[INWIDTH-1:0];
            d_d     = divisor;
            cnt_d   = CW'(INWIDTH);
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        r_d   = step_r;
        q_d   = {q_q[INWIDTH-2:0], step_qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d  = {q_q[INWIDTH-2:0], step_qbit};
          rem_d   = step_r;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (out_ready) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    out_valid_d = (state_d == DIV_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == DIV_IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_mm_div_seq.sv
// Bench for mm_div_seq: vector table, hand-written corner sequences and
// randomized operand pairs checked against an arithmetic reference model.
module tb_mm_div_seq;
  import mm_defs::*;

  localparam int IW = 16;
  localparam int OW = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] dividend;
  logic [IW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] quotient;
  logic [IW-1:0] remainder;
  logic          dbz;
  logic          ovf;
  logic [1:0]    dbg_state;

  always #(CLOCK_PERIOD / 2) clk = ~clk;

  mm_div_seq #(.INWIDTH(IW), .OUTWIDTH(OW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .dbz      (dbz),
    .ovf      (ovf),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected results as {quotient, remainder, dbz, ovf}.
  logic [IW+IW+1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain integer division with the error rules.
  function automatic logic [IW+IW+1:0] model(input logic [OW-1:0] n, input logic [IW-1:0] d);
    logic [OW-1:0] qq;
    logic [OW-1:0] rr;
    if (d == 0) return {16'hFFFF, n[IW-1:0], 1'b1, 1'b0};
    qq = n / OW'(d);
    rr = n % OW'(d);
    if (qq > 32'h0000FFFF) return {16'hFFFF, 16'h0000, 1'b0, 1'b1};
    return {qq[IW-1:0], rr[IW-1:0], 1'b0, 1'b0};
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one operation from the negedge; lat counts rising edges from the
  // accept edge to the first edge at which out_valid is seen high.
  task automatic run_op(input logic [OW-1:0] n, input logic [IW-1:0] d, input int hold,
                        input bit noisy_ready, output logic [IW+IW+1:0] res, output int lat);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = n;
    divisor  = d;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (noisy_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    if (!out_valid) check("done_timeout", 64'(out_valid), 64'(1));
    res = {quotient, remainder, dbz, ovf};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_result", 64'({quotient, remainder, dbz, ovf}), 64'(res));
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_ack_out_valid", 64'(out_valid), 64'(0));
    check("post_ack_in_ready", 64'(in_ready), 64'(1));
    check("post_ack_retain", 64'({quotient, remainder, dbz, ovf}), 64'(res));
  endtask

  typedef struct {
    logic [OW-1:0] n;
    logic [IW-1:0] d;
    logic [IW-1:0] q;
    logic [IW-1:0] r;
    logic          z;
    logic          o;
    int            lat;
    int            hold;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #(CLOCK_PERIOD * 200000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [IW+IW+1:0] res;
    logic [IW+IW+1:0] exp;
    int               lat;
    logic [OW-1:0]    n;
    logic [IW-1:0]    d;
    int               mode;

    vecs[0] = '{32'd100,       16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 17, 5};
    vecs[1] = '{32'hFFFE0001,  16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b0, 17, 0};
    vecs[2] = '{32'h00010000,  16'h0001,   16'hFFFF,   16'h0000,   1'b0, 1'b1, 1,  0};
    vecs[3] = '{32'h00001234,  16'h0000,   16'hFFFF,   16'h1234,   1'b1, 1'b0, 1,  2};
    vecs[4] = '{32'h00000000,  16'd5,      16'd0,      16'd0,      1'b0, 1'b0, 17, 0};
    vecs[5] = '{32'hFFFFFFFF,  16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b1, 1,  0};
    vecs[6] = '{32'h0000FFFF,  16'h0001,   16'hFFFF,   16'h0000,   1'b0, 1'b0, 17, 0};
    vecs[7] = '{32'h0001FFFF,  16'h0002,   16'hFFFF,   16'h0001,   1'b0, 1'b0, 17, 1};
    vecs[8] = '{32'd1000,      16'd3,      16'd333,    16'd1,      1'b0, 1'b0, 17, 0};

    // Reset state.
    do_reset();
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_result", 64'({quotient, remainder, dbz, ovf}), 64'(0));

    // Table-driven vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].n, vecs[i].d, vecs[i].hold, 1'b0, res, lat);
      check($sformatf("vec%0d_result", i), 64'(res),
            64'({vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].o}));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Reset in the middle of a calculation aborts it.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd1000;
    divisor  = 16'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_out_valid", 64'(out_valid), 64'(0));
    check("midreset_in_ready", 64'(in_ready), 64'(1));
    check("midreset_result", 64'({quotient, remainder, dbz, ovf}), 64'(0));
    repeat (20) @(negedge clk);
    check("midreset_no_result", 64'(out_valid), 64'(0));
    run_op(32'd9, 16'd2, 0, 1'b0, res, lat);
    check("after_reset_9_2", 64'(res), 64'({16'd4, 16'd1, 1'b0, 1'b0}));
    check("after_reset_latency", 64'(lat), 64'(17));

    // Randomized pairs against the reference model.
    for (int k = 0; k < 1500; k++) begin
      mode = int'($urandom_range(0, 19));
      if (mode == 0) begin
        d = '0;
        n = $urandom;
      end else if (mode == 1) begin
        d = 16'($urandom_range(1, 65535));
        n = $urandom;
      end else begin
        if (mode < 7) d = 16'($urandom_range(1, 255));
        else          d = 16'($urandom_range(1, 65535));
        n = {16'($urandom % d), 16'($urandom)};
      end
      exp_q.push_back(model(n, d));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(n, d, int'($urandom_range(0, 3)), 1'b1, res, lat);
      exp = exp_q.pop_front();
      check($sformatf("rand%0d_result n=%0h d=%0h", k, n, d), 64'(res), 64'(exp));
      if (!exp[1] && !exp[0]) begin
        check("rand_identity", 64'(OW'(res[33:18]) * OW'(d) + OW'(res[17:2])), 64'(n));
        check("rand_rem_lt_div", 64'(res[17:2] < d), 64'(1));
        check("rand_latency", 64'(lat), 64'(17));
      end else begin
        check("rand_err_latency", 64'(lat), 64'(1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
